trng_collector: RTL
===================

// Module: trng_collector
// PURPOSE
//  Entropy-side responder of the stop/valid random-number handshake used by the die-roll post-processor.
//  Samples a raw ring-oscillator bit through a synchronizer and assembles WIDTH bits into a word.
//  Optionally removes bias from the bits, then presents the word with o_valid until the consumer accepts it.
//  Sits between the analog-ish oscillator macro and the post-processing FSM.
// PARAMETERS
//  WIDTH        7   bits per random word (matches consumer's random-data input)
//  SYNC_STAGES  2   flops in i_raw synchronizer chain, legal range 2..4
//  SAMPLE_DIV   4   run-cycles between samples (decorrelation), legal range 1..255
// PORTS
//  i_clk         in   1      system clock, all logic on posedge
//  i_reset       in   1      synchronous, active-high reset
//  i_stop        in   1      from consumer: 1 = halt/oscillator reset, 0 = run
//  i_raw         in   1      asynchronous raw entropy bit from ring oscillator
//  o_osc_en      out  1      oscillator enable, registered copy of !i_stop
//  o_valid       out  1      o_randomData holds a complete word
//  o_randomData  out  WIDTH  assembled random word
// BEHAVIOUR
//  Reset (i_reset=1 at posedge): o_valid=0, o_randomData=0, o_osc_en=0, synchronizer=0, bit count=0,
//   divider=0, pair flag=0, state=S_COLLECT. Reset is honoured in every state, mid-word included; partial bits are discarded.
//  Synchronizer: i_raw passes through SYNC_STAGES flops every cycle regardless of state; s_raw is the last stage.
//  o_osc_en <= !i_stop each cycle, 1-cycle latency; it is 0 during reset.
//  Divider: counts only cycles with i_stop=0 in S_COLLECT; it holds its value while i_stop=1.
//   A sample tick fires when divider==SAMPLE_DIV-1, and the divider then wraps to 0.
//  FSM, 2 states:
//   S_COLLECT: on each tick a candidate bit is taken from s_raw; an accepted bit shifts into shreg LSB
//    (shreg <= {shreg[WIDTH-2:0],bit}), so the first accepted bit ends at [WIDTH-1]. The bit count increments.
//    When the WIDTH-th bit is accepted: o_randomData <= new shreg value, o_valid <= 1, bit count <= 0,
//    next state S_VALID (valid is visible the cycle after the final tick).
//    i_stop=1 only pauses the block; collected bits are kept, so a consumer toggling stop every cycle still progresses.
//   S_VALID: o_randomData frozen, no sampling, divider held at 0.
//    Accept = o_valid & i_stop at posedge -> o_valid <= 0, pair flag cleared, back to S_COLLECT.
//    o_randomData keeps the last word after accept. While i_stop=0 and o_valid=1, the block holds indefinitely.
//  Same-cycle completion and stop=1: the completion is not possible, because a tick requires i_stop=0.
//  Bit count width is clog2(WIDTH+1); shreg width is WIDTH; no arithmetic overflow is possible.
// CONFIGURATION
//  TRNG_VON_NEUMANN_EN defined: ticks are paired. The first tick of a pair stores s_raw and sets the pair flag.
//   On the second tick: 01 -> accept 0, 10 -> accept 1, 00/11 -> discard; the pair flag clears in all cases.
//   Only accepted bits count. Word latency is data-dependent and unbounded for a constant i_raw.
//  Not defined: every tick accepts s_raw directly; the pair flag logic is absent.
//   Word latency = WIDTH*SAMPLE_DIV run-cycles + 1 after the first run cycle.
// TESTING
//  1 Reset: hold i_reset 3 cycles with i_raw toggling -> o_valid=0, o_randomData=0, o_osc_en=0.
//    Release the reset and hold i_stop=1 for 50 cycles -> o_valid stays 0.
//  2 No VN, SAMPLE_DIV=1, i_stop=0, synchronized s_raw sequence 1,0,1,1,0,0,1 -> o_valid=1 with o_randomData=7'h59.
//    Hold i_stop=0 for 20 more cycles -> word unchanged.
//  3 Accept: with o_valid=1, pulse i_stop=1 for one cycle -> o_valid=0 next cycle, o_randomData still 7'h59.
//    The next word starts from a zero bit count.
//  4 Stop toggling 1,0,1,0,... with SAMPLE_DIV=4 and i_raw=1 -> valid after 7*4 stop-low cycles, word 7'h7F.
//  5 VN on: s_raw pairs 01,11,10,00,10,01,01,10,10 -> accepted bits 0,1,1,0,0,1,1 -> o_randomData=7'h33.
//    Constant i_raw=0 for 1000 cycles -> o_valid stays 0.
//  6 Reset mid-word after 4 bits, then 7 ones -> o_randomData=7'h7F; none of the earlier bits appear.

Source files
------------

// File: rtl/trng_collector.sv
// Synchronizes a ring-oscillator bit, samples it every SAMPLE_DIV run cycles and assembles WIDTH-bit words; define TRNG_VON_NEUMANN_EN for pairwise debiasing.
// Word ready WIDTH*SAMPLE_DIV run cycles + 1 after start (no debias); i_stop=1 pauses collection, or accepts a held word.
module trng_collector #(
  parameter int unsigned WIDTH       = 7,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned SAMPLE_DIV  = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_stop,
  input  logic             i_raw,
  output logic             o_osc_en,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_randomData
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic {S_COLLECT, S_VALID} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [7:0]             div_q, div_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [WIDTH-1:0]       shreg_q, shreg_d;
  logic [WIDTH-1:0]       data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   osc_q;
  logic                   s_raw;
  logic                   tick;
  logic                   take;
  logic                   take_bit;

  assign s_raw = sync_q[SYNC_STAGES-1];
  assign tick  = (state_q == S_COLLECT) && !i_stop && (div_q == 8'(SAMPLE_DIV - 1));

`ifdef TRNG_VON_NEUMANN_EN
  logic pair_q, pair_d;
  logic first_q, first_d;

  // Second tick of a pair keeps the first bit only when the two differ (10 -> 1, 01 -> 0).
  always_comb begin
    pair_d   = pair_q;
    first_d  = first_q;
    take     = 1'b0;
    take_bit = first_q;
    if (tick) begin
      if (!pair_q) begin
        pair_d  = 1'b1;
        first_d = s_raw;
      end else begin
        pair_d = 1'b0;
        take   = first_q ^ s_raw;
      end
    end
    if ((state_q == S_VALID) && i_stop) pair_d = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pair_q  <= 1'b0;
      first_q <= 1'b0;
    end else begin
      pair_q  <= pair_d;
      first_q <= first_d;
    end
  end
`else
  always_comb begin
    take     = tick;
    take_bit = s_raw;
  end
`endif

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = valid_q;
    case (state_q)
      S_COLLECT: begin
        if (!i_stop) div_d = tick ? 8'd0 : div_q + 8'd1;
        if (take) begin
          shreg_d = {shreg_q[WIDTH-2:0], take_bit};
          if (cnt_q == CW'(WIDTH - 1)) begin
            data_d  = shreg_d;
            valid_d = 1'b1;
            cnt_d   = '0;
            state_d = S_VALID;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_VALID: begin
        div_d = 8'd0;
        if (i_stop) begin
          valid_d = 1'b0;
          state_d = S_COLLECT;
        end
      end
      default: state_d = S_COLLECT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync_q  <= '0;
      state_q <= S_COLLECT;
      div_q   <= 8'd0;
      cnt_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      osc_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], i_raw};
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      osc_q   <= !i_stop;
    end
  end

  assign o_osc_en     = osc_q;
  assign o_valid      = valid_q;
  assign o_randomData = data_q;

endmodule
